// File: rtl/screen_seq_pkg.sv
// Shared types and constants for the screen sequencer: FSM state encoding,
// the default idle pixel and the per-cycle step-request decode.
package screen_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        NEXT = 2'd1,
        PREV = 2'd2
    } step_t;

    localparam logic [15:0] BLANK_COLOR_DEFAULT = 16'h0000;

    // Simultaneous next and prev requests cancel each other out.
    function automatic step_t decode_step(input logic nxt, input logic prv);
        case ({nxt, prv})
            2'b10:   decode_step = NEXT;
            2'b01:   decode_step = PREV;
            default: decode_step = NONE;
        endcase
    endfunction

endpackage

// File: rtl/screen_sequencer_btn_debounce.sv
// Button debouncer: the level flips after DEBOUNCE_CYCLES consecutive cycles
// of disagreement; rise pulses for one cycle on each accepted press.
module btn_debounce
    import screen_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            level_q <= level;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= raw;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/screen_sequencer.sv
// Selects one of NUM_SCREENS renderer pixels for the OLED with debounced
// next/prev navigation. Optional autoplay: define SCREEN_SEQUENCER_AUTOPLAY_EN.
module screen_sequencer
    import screen_seq_pkg::*;
#(
    parameter int               NUM_SCREENS     = 11,
    parameter int               PIX_W           = 16,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter int               WRAP            = 1,
    parameter logic [PIX_W-1:0] BLANK_COLOR     = PIX_W'(BLANK_COLOR_DEFAULT),
`ifdef SCREEN_SEQUENCER_AUTOPLAY_EN
    parameter int               DWELL_FRAMES    = 120,
`endif
    localparam int              IDX_W           = $clog2(NUM_SCREENS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         btn_next,
    input  logic                         btn_prev,
    input  logic                         frame_tick,
    input  logic [NUM_SCREENS*PIX_W-1:0] screen_pix,
    output logic [PIX_W-1:0]             oled_data,
    output logic [IDX_W-1:0]             screen_idx,
    output logic                         active
);

    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(NUM_SCREENS - 1);

    state_t         state, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W:0] idx_calc;
    logic           next_rise, prev_rise;
    logic           next_lvl_unused, prev_lvl_unused;
    step_t          step_req, step_sel;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_next),
        .level (next_lvl_unused),
        .rise  (next_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_prev),
        .level (prev_lvl_unused),
        .rise  (prev_rise)
    );

    assign step_req = decode_step(next_rise, prev_rise);

    // One extra bit of headroom so the +1/-1 never aliases before the end checks.
    function automatic logic [IDX_W:0] step_idx(input logic [IDX_W:0] cur, input step_t dir);
        step_idx = cur;
        case (dir)
            NEXT: begin
                if (cur == LAST_IDX) step_idx = (WRAP != 0) ? '0 : cur;
                else                 step_idx = cur + 1'b1;
            end
            PREV: begin
                if (cur == '0) step_idx = (WRAP != 0) ? LAST_IDX : cur;
                else           step_idx = cur - 1'b1;
            end
            default: step_idx = cur;
        endcase
    endfunction

`ifdef SCREEN_SEQUENCER_AUTOPLAY_EN
    localparam int FRM_W = $clog2(DWELL_FRAMES + 1);
    logic [FRM_W-1:0] frame_cnt, frame_nxt;
`else
    logic frame_tick_unused;
    assign frame_tick_unused = frame_tick;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            screen_idx <= '0;
`ifdef SCREEN_SEQUENCER_AUTOPLAY_EN
            frame_cnt  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            screen_idx <= idx_nxt;
`ifdef SCREEN_SEQUENCER_AUTOPLAY_EN
            frame_cnt  <= frame_nxt;
`endif
        end
    end

    // Dropping enable wins over any step; the index sits at 0 while idle.
    always_comb begin
        state_nxt = enable ? SHOW : IDLE;
        step_sel  = NONE;
`ifdef SCREEN_SEQUENCER_AUTOPLAY_EN
        frame_nxt = '0;
`endif
        if (state == SHOW && enable) begin
            step_sel = step_req;
`ifdef SCREEN_SEQUENCER_AUTOPLAY_EN
            frame_nxt = frame_cnt;
            if (step_req != NONE) begin
                frame_nxt = '0;
            end else if (frame_tick) begin
                if (frame_cnt == FRM_W'(DWELL_FRAMES - 1)) begin
                    frame_nxt = '0;
                    step_sel  = NEXT;
                end else begin
                    frame_nxt = frame_cnt + 1'b1;
                end
            end
`endif
        end
        idx_calc = step_idx({1'b0, screen_idx}, step_sel);
        idx_nxt  = (state == SHOW && enable) ? idx_calc[IDX_W-1:0] : '0;
    end

    always_comb begin
        oled_data = BLANK_COLOR;
        active    = 1'b0;
        if (state == SHOW) begin
            oled_data = screen_pix[int'(screen_idx)*PIX_W +: PIX_W];
            active    = 1'b1;
        end
    end

endmodule
